// File: rtl/reg_bank_wr_arb.sv
// rtl/reg_bank_wr_arb.sv - write-port arbiter and init sequencer for reg_bank
//
// Two requesters share reg_bank's single write port through valid/ready
// handshakes, arbitrated round-robin. An optional sequencer clears every
// register to zero after reset before any requester is served.
//
// Optional feature macro: REG_BANK_ARB_INIT_EN (defined = INIT sequencer
// compiled in; undefined = reset enters ARB directly).
//
// Parameters:
//   W - register data width
//   N - address width (bank holds 2^N registers)
// Ports:
//   clk                  system clock, rising edge
//   reset                asynchronous active-low reset
//   req0_valid/addr/data requester 0 write request
//   req0_ready           requester 0 granted this cycle (combinational)
//   req1_*               same for requester 1
//   bank_we/addr/data    registered write port into reg_bank
//   grant_id             source of the current bank_* write (0 during INIT)
//   init_done            high while the block is in ARB
module reg_bank_wr_arb #(
  parameter int W = 7,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_addr,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_addr,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         bank_we,
  output logic [N-1:0] bank_addr,
  output logic [W-1:0] bank_data,
  output logic         grant_id,
  output logic         init_done
);

  typedef enum logic {ST_INIT = 1'b0, ST_ARB = 1'b1} state_t;

  state_t       state;
  state_t       state_next;
  logic         prio;
  logic         arb_active;
  logic         grant0;
  logic         grant1;
  logic         init_wr;
  logic [N-1:0] init_addr;

`ifdef REG_BANK_ARB_INIT_EN
  localparam state_t         RST_STATE = ST_INIT;
  localparam logic   [N:0]   INIT_LAST = {1'b0, {N{1'b1}}};
  logic [N:0] init_cnt;

  assign init_addr = init_cnt[N-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      init_cnt <= '0;
    else if (init_wr)
      init_cnt <= init_cnt + (N+1)'(1);
  end
`else
  localparam state_t RST_STATE = ST_ARB;
  assign init_addr = '0;
`endif

  // Gating with reset keeps readies and init_done low while reset is held,
  // which matters when reset enters ARB directly.
  assign arb_active = (state == ST_ARB) & reset;

  // prio names the requester that wins when both are valid.
  assign grant0 = arb_active & req0_valid & (~req1_valid | ~prio);
  assign grant1 = arb_active & req1_valid & (~req0_valid |  prio);

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign init_done  = arb_active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= RST_STATE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    init_wr    = 1'b0;
`ifdef REG_BANK_ARB_INIT_EN
    if (state == ST_INIT) begin
      init_wr = 1'b1;
      if (init_cnt == INIT_LAST)
        state_next = ST_ARB;
    end
`endif
  end

  // bank_addr/data/grant_id only move when a write is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_we   <= 1'b0;
      bank_addr <= '0;
      bank_data <= '0;
      grant_id  <= 1'b0;
      prio      <= 1'b0;
    end else if (init_wr) begin
      bank_we   <= 1'b1;
      bank_addr <= init_addr;
      bank_data <= '0;
      grant_id  <= 1'b0;
    end else if (grant0) begin
      bank_we   <= 1'b1;
      bank_addr <= req0_addr;
      bank_data <= req0_data;
      grant_id  <= 1'b0;
      prio      <= 1'b1;
    end else if (grant1) begin
      bank_we   <= 1'b1;
      bank_addr <= req1_addr;
      bank_data <= req1_data;
      grant_id  <= 1'b1;
      prio      <= 1'b0;
    end else begin
      bank_we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_bank_wr_arb.sv
// tb/tb_reg_bank_wr_arb.sv - self-checking bench for reg_bank_wr_arb
module tb_reg_bank_wr_arb;

  localparam int W     = 7;
  localparam int N     = 4;
  localparam int DEPTH = 1 << N;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [N-1:0] req0_addr, req1_addr;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         bank_we;
  logic [N-1:0] bank_addr;
  logic [W-1:0] bank_data;
  logic         grant_id;
  logic         init_done;

  always #5 clk = ~clk;

  reg_bank_wr_arb #(.W(W), .N(N)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .bank_we(bank_we), .bank_addr(bank_addr), .bank_data(bank_data),
    .grant_id(grant_id), .init_done(init_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who won last, how many init writes remain, and the
  // write expected on the bank port this cycle.
  bit           in_arb;
  int           init_left;
  bit           last_win;
  bit           last_g0, last_g1;
  logic         exp_we;
  logic [N-1:0] exp_addr;
  logic [W-1:0] exp_data;
  logic         exp_gid;
  logic [W-1:0] mem_dut [DEPTH];

  typedef struct {
    logic         v0;
    logic [N-1:0] a0;
    logic [W-1:0] d0;
    logic         v1;
    logic [N-1:0] a1;
    logic [W-1:0] d1;
    logic         r0;
    logic         r1;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_gid = 1'b0;
    last_win = 1'b1;   // behaves as if requester 1 won last: requester 0 first
    last_g0 = 1'b0; last_g1 = 1'b0;
`ifdef REG_BANK_ARB_INIT_EN
    in_arb = 1'b0; init_left = DEPTH;
`else
    in_arb = 1'b1; init_left = 0;
`endif
  endtask

  function automatic void model_grant(input bit v0, input bit v1, output bit g0, output bit g1);
    g0 = 1'b0; g1 = 1'b0;
    if (in_arb) begin
      if (v0 && v1) begin
        if (last_win) g0 = 1'b1; else g1 = 1'b1;
      end else begin
        g0 = v0; g1 = v1;
      end
    end
  endfunction

  task automatic check_outputs(input bit g0, input bit g1);
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("init_done",  init_done,  in_arb);
    chk("bank_we",    bank_we,    exp_we);
    chk("bank_addr",  bank_addr,  exp_addr);
    chk("bank_data",  bank_data,  exp_data);
    chk("grant_id",   grant_id,   exp_gid);
    if (bank_we === 1'b1) mem_dut[bank_addr] = bank_data;
  endtask

  // Entered 1 time unit after a rising edge with inputs already driven.
  task automatic cycle();
    bit g0, g1;
    #2;
    model_grant(req0_valid, req1_valid, g0, g1);
    check_outputs(g0, g1);
    @(posedge clk);
    if (!in_arb) begin
      exp_we = 1'b1; exp_addr = N'(DEPTH - init_left); exp_data = '0; exp_gid = 1'b0;
      init_left--;
      if (init_left == 0) in_arb = 1'b1;
    end else if (g0) begin
      exp_we = 1'b1; exp_addr = req0_addr; exp_data = req0_data; exp_gid = 1'b0; last_win = 1'b0;
    end else if (g1) begin
      exp_we = 1'b1; exp_addr = req1_addr; exp_data = req1_data; exp_gid = 1'b1; last_win = 1'b1;
    end else begin
      exp_we = 1'b0;
    end
    last_g0 = g0; last_g1 = g1;
    #1;
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b0;
    #1;
    chk({nm, " bank_we"},    bank_we,    1'b0);
    chk({nm, " bank_addr"},  bank_addr,  '0);
    chk({nm, " bank_data"},  bank_data,  '0);
    chk({nm, " grant_id"},   grant_id,   1'b0);
    chk({nm, " init_done"},  init_done,  1'b0);
    chk({nm, " req0_ready"}, req0_ready, 1'b0);
    chk({nm, " req1_ready"}, req1_ready, 1'b0);
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic drive_random();
    if (!(req0_valid && !last_g0)) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_addr  = N'($urandom_range(0, DEPTH - 1));
      req0_data  = W'($urandom_range(0, (1 << W) - 1));
    end
    if (!(req1_valid && !last_g1)) begin
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_addr  = N'($urandom_range(0, DEPTH - 1));
      req1_data  = W'($urandom_range(0, (1 << W) - 1));
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'd9,  7'h7f, 1'b0, 4'd0, 7'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 4'd0,  7'h00, 1'b1, 4'd5, 7'h2a, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 4'd3,  7'h11, 1'b1, 4'd3, 7'h22, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'd0,  7'h00, 1'b1, 4'd3, 7'h22, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 4'd1,  7'h01, 1'b1, 4'd2, 7'h02, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'd4,  7'h04, 1'b1, 4'd2, 7'h02, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 4'd4,  7'h04, 1'b1, 4'd6, 7'h06, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'd7,  7'h07, 1'b1, 4'd6, 7'h06, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 4'd0,  7'h00, 1'b0, 4'd0, 7'h00, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd15, 7'h7f, 1'b0, 4'd0, 7'h00, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'd0,  7'h55, 1'b1, 4'd8, 7'h33, 1'b0, 1'b1};

    for (int i = 0; i < DEPTH; i++) mem_dut[i] = '0;
    model_reset();
    reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 4'd9; req0_data = 7'h7f;
    req1_valid = 1'b0; req1_addr = '0;   req1_data = '0;

    // Reset values while held in reset with a request pending.
    @(posedge clk);
    do_reset("reset");

`ifdef REG_BANK_ARB_INIT_EN
    // Both requesters hold valid through INIT; abort at cycle 7, then rerun.
    req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 7'h2a;
    for (int c = 0; c < 7; c++) cycle();
    chk("init cycle7 bank_addr", bank_addr, 4'd6);
    do_reset("reset mid-init");
    for (int c = 0; c < DEPTH; c++) cycle();
    chk("init_done after init", init_done, 1'b1);
    for (int i = 0; i < DEPTH; i++) mem_dut[i] = 7'h7e;
`endif

    for (int i = 0; i < 11; i++) begin
      req0_valid = vecs[i].v0; req0_addr = vecs[i].a0; req0_data = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_addr = vecs[i].a1; req1_data = vecs[i].d1;
      #1;
      chk($sformatf("vec%0d req0_ready", i), req0_ready, vecs[i].r0);
      chk($sformatf("vec%0d req1_ready", i), req1_ready, vecs[i].r1);
      cycle();
    end
    chk("same-addr last write", mem_dut[3], 7'h22);

    for (int c = 0; c < 400; c++) begin
      drive_random();
      cycle();
    end

    // Reset while a granted write is on the bank port.
    req0_valid = 1'b1; req0_addr = 4'd12; req0_data = 7'h3c;
    req1_valid = 1'b0;
    cycle();
    chk("pre-reset bank_we", bank_we, 1'b1);
    do_reset("reset mid-grant");
    req0_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      drive_random();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
